// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one memory-controller port between the fetch and the
//            load/store ports: data priority, fetch aging, BUSY watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int TIMEOUT      = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_enable,
  input  logic [24:0] instr_addr,
  output logic        instr_valid,
  output logic [31:0] instr_result,
  input  logic        data_enable,
  input  logic [24:0] data_addr,
  input  logic        data_we,
  input  logic [31:0] data_wdata,
  input  logic [1:0]  data_oplen,
  input  logic        data_unsigned,
  output logic        data_valid,
  output logic [31:0] data_result,
  output logic        m_instr_enable,
  output logic [24:0] m_instr_addr,
  input  logic        m_instr_valid,
  input  logic [31:0] m_instr_result,
  output logic        m_data_enable,
  output logic [24:0] m_data_addr,
  output logic        m_data_we,
  output logic [31:0] m_data_wdata,
  output logic [1:0]  m_data_oplen,
  output logic        m_data_unsigned,
  input  logic        m_data_valid,
  input  logic [31:0] m_data_result,
  output logic        busy,
  output logic        timeout_err
);

  localparam int              c_WW       = $clog2(STARVE_LIMIT + 1);
  localparam int              c_TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_WW-1:0] c_STARVE   = c_WW'(STARVE_LIMIT);
  localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(TIMEOUT - 1);
  localparam logic [31:0]     c_TMO_WORD = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_gnt_data;
  logic            r_abandon;
  logic [c_WW-1:0] r_wait_cnt;
  logic [c_TW-1:0] r_tmo_cnt;

  logic w_data_win;
  logic w_m_valid;
  logic w_req_live;
  logic w_expire;
  logic w_pulse;

  assign w_data_win = data_enable && (r_wait_cnt < c_STARVE);
  assign w_m_valid  = r_gnt_data ? m_data_valid : m_instr_valid;
  assign w_req_live = r_gnt_data ? data_enable : instr_enable;
  assign w_expire   = (TIMEOUT != 0) && (r_tmo_cnt == c_TMO_LAST);
  // A requester that let go of enable at any point in BUSY gets no pulse.
  assign w_pulse    = w_req_live && !r_abandon;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_gnt_data      <= 1'b0;
      r_abandon       <= 1'b0;
      r_wait_cnt      <= '0;
      r_tmo_cnt       <= '0;
      instr_valid     <= 1'b0;
      instr_result    <= '0;
      data_valid      <= 1'b0;
      data_result     <= '0;
      m_instr_enable  <= 1'b0;
      m_instr_addr    <= '0;
      m_data_enable   <= 1'b0;
      m_data_addr     <= '0;
      m_data_we       <= 1'b0;
      m_data_wdata    <= '0;
      m_data_oplen    <= '0;
      m_data_unsigned <= 1'b0;
      busy            <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      data_valid  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_data_win) begin
            r_state         <= S_BUSY;
            busy            <= 1'b1;
            r_gnt_data      <= 1'b1;
            r_abandon       <= 1'b0;
            r_tmo_cnt       <= '0;
            m_data_enable   <= 1'b1;
            m_data_addr     <= data_addr;
            m_data_we       <= data_we;
            m_data_wdata    <= data_wdata;
            m_data_oplen    <= data_oplen;
            m_data_unsigned <= data_unsigned;
            if (instr_enable) begin
              r_wait_cnt <= r_wait_cnt + 1'b1;
            end
          end else if (instr_enable) begin
            r_state        <= S_BUSY;
            busy           <= 1'b1;
            r_gnt_data     <= 1'b0;
            r_abandon      <= 1'b0;
            r_tmo_cnt      <= '0;
            r_wait_cnt     <= '0;
            m_instr_enable <= 1'b1;
            m_instr_addr   <= instr_addr;
          end
        end
        S_BUSY: begin
          r_tmo_cnt <= r_tmo_cnt + 1'b1;
          if (!w_req_live) begin
            r_abandon <= 1'b1;
          end
          // A valid on the expiry edge wins over the watchdog.
          if (w_m_valid || w_expire) begin
            r_state        <= S_DONE;
            m_instr_enable <= 1'b0;
            m_data_enable  <= 1'b0;
            if (!w_m_valid) begin
              timeout_err <= 1'b1;
            end
            if (r_gnt_data) begin
              data_valid  <= w_pulse;
              data_result <= w_m_valid ? m_data_result : c_TMO_WORD;
            end else begin
              instr_valid  <= w_pulse;
              instr_result <= w_m_valid ? m_instr_result : c_TMO_WORD;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench: vector table, directed corner sequences and
//            a randomized run against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int          STARVE = 2;
  localparam int          TMO    = 16;
  localparam logic [31:0] c_BEEF = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_enable = 1'b0;
  logic [24:0] instr_addr = '0;
  logic        instr_valid;
  logic [31:0] instr_result;
  logic        data_enable = 1'b0;
  logic [24:0] data_addr = '0;
  logic        data_we = 1'b0;
  logic [31:0] data_wdata = '0;
  logic [1:0]  data_oplen = '0;
  logic        data_unsigned = 1'b0;
  logic        data_valid;
  logic [31:0] data_result;
  logic        m_instr_enable;
  logic [24:0] m_instr_addr;
  logic        m_instr_valid = 1'b0;
  logic [31:0] m_instr_result = '0;
  logic        m_data_enable;
  logic [24:0] m_data_addr;
  logic        m_data_we;
  logic [31:0] m_data_wdata;
  logic [1:0]  m_data_oplen;
  logic        m_data_unsigned;
  logic        m_data_valid = 1'b0;
  logic [31:0] m_data_result = '0;
  logic        busy;
  logic        timeout_err;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(STARVE), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .instr_enable(instr_enable), .instr_addr(instr_addr),
    .instr_valid(instr_valid), .instr_result(instr_result),
    .data_enable(data_enable), .data_addr(data_addr), .data_we(data_we),
    .data_wdata(data_wdata), .data_oplen(data_oplen), .data_unsigned(data_unsigned),
    .data_valid(data_valid), .data_result(data_result),
    .m_instr_enable(m_instr_enable), .m_instr_addr(m_instr_addr),
    .m_instr_valid(m_instr_valid), .m_instr_result(m_instr_result),
    .m_data_enable(m_data_enable), .m_data_addr(m_data_addr), .m_data_we(m_data_we),
    .m_data_wdata(m_data_wdata), .m_data_oplen(m_data_oplen),
    .m_data_unsigned(m_data_unsigned), .m_data_valid(m_data_valid),
    .m_data_result(m_data_result), .busy(busy), .timeout_err(timeout_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Called at the falling edge of the first BUSY cycle; returns in DONE.
  // lat = -1 models a controller that never answers.
  task automatic serve(input bit is_data, input int lat, input logic [31:0] rd,
                       input bit exp_pulse, input int drop_at, input string nm);
    logic [31:0] exp_r;
    int          c;
    bit          fin;
    c     = 0;
    fin   = 1'b0;
    exp_r = c_BEEF;
    while (!fin) begin
      chk({nm, " enable held"}, 32'({m_data_enable, m_instr_enable}), is_data ? 2 : 1);
      chk({nm, " no early valid"}, 32'({data_valid, instr_valid}), 0);
      if (c == drop_at) begin
        if (is_data) data_enable = 1'b0; else instr_enable = 1'b0;
      end
      if (c == lat) begin
        exp_r = rd;
        if (is_data) begin m_data_valid = 1'b1; m_data_result = rd; end
        else begin m_instr_valid = 1'b1; m_instr_result = rd; end
      end
      fin = (c == lat) || (c == TMO - 1);
      c++;
      @(negedge clk);
      m_data_valid  = 1'b0;
      m_instr_valid = 1'b0;
    end
    chk({nm, " valid pulse"}, 32'({data_valid, instr_valid}),
        exp_pulse ? (is_data ? 2 : 1) : 0);
    if (exp_pulse) chk({nm, " result"}, is_data ? data_result : instr_result, exp_r);
    chk({nm, " enables dropped"}, 32'({m_data_enable, m_instr_enable}), 0);
    chk({nm, " busy in done"}, 32'(busy), 1);
  endtask

  typedef struct {
    bit          ie;
    bit          de;
    bit          we;
    int          lat;
    logic [31:0] rd;
    bit          gd;   // expected winner: 1 = data
  } vec_t;
  vec_t tv[8];

  // reference-model state for the randomized run
  int          losses, gnt, due, c, lat, gi, gd;
  bit          due_tmo, tflag, pbusy, pie, pde, ebusy, win_d, win_i;
  logic [1:0]  ev, een;
  logic [31:0] resp, exp_res;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tv[0] = '{1'b1, 1'b0, 1'b0,  3, 32'h0000_0013, 1'b0};
    tv[1] = '{1'b0, 1'b1, 1'b0,  0, 32'hA5A5_0001, 1'b1};
    tv[2] = '{1'b0, 1'b1, 1'b1,  5, 32'h1234_5678, 1'b1};
    tv[3] = '{1'b1, 1'b1, 1'b0,  1, 32'hCAFE_0003, 1'b1};
    tv[4] = '{1'b1, 1'b1, 1'b1,  2, 32'hCAFE_0004, 1'b1};
    tv[5] = '{1'b1, 1'b1, 1'b0,  1, 32'hCAFE_0005, 1'b0};
    tv[6] = '{1'b1, 1'b1, 1'b0, 15, 32'h0BAD_F00D, 1'b1};
    tv[7] = '{1'b1, 1'b0, 1'b0,  7, 32'h7777_0007, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset enables", 32'({m_data_enable, m_instr_enable}), 0);
    chk("reset valids", 32'({data_valid, instr_valid}), 0);
    chk("reset instr_result", instr_result, 0);
    chk("reset data_result", data_result, 0);
    chk("reset m_data_addr", 32'(m_data_addr), 0);
    chk("reset busy/terr", 32'({busy, timeout_err}), 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      instr_enable  = tv[i].ie;
      data_enable   = tv[i].de;
      instr_addr    = 25'h100 + 25'(i * 4);
      data_addr     = 25'h1000 + 25'(i * 4);
      data_we       = tv[i].we;
      data_wdata    = ~tv[i].rd;
      data_oplen    = 2'(i);
      data_unsigned = 1'(i);
      @(negedge clk);
      chk("tv grant", 32'({m_data_enable, m_instr_enable}), tv[i].gd ? 2 : 1);
      if (tv[i].gd) begin
        chk("tv m_data_addr", 32'(m_data_addr), 32'h1000 + 32'(i * 4));
        chk("tv m_data_wdata", m_data_wdata, ~tv[i].rd);
        chk("tv m_data ctl", 32'({m_data_we, m_data_oplen, m_data_unsigned}),
            32'({tv[i].we, 2'(i), 1'(i)}));
      end else begin
        chk("tv m_instr_addr", 32'(m_instr_addr), 32'h100 + 32'(i * 4));
      end
      serve(tv[i].gd, tv[i].lat, tv[i].rd, 1'b1, -1, "tv");
      instr_enable = 1'b0;
      data_enable  = 1'b0;
      @(negedge clk);
      chk("tv idle after done", 32'({busy, m_data_enable, m_instr_enable}), 0);
    end
    chk("no timeout yet", 32'(timeout_err), 0);

    // simultaneous requests: data first, fetch right after data's DONE
    @(negedge clk);
    instr_enable = 1'b1; instr_addr = 25'h200;
    data_enable  = 1'b1; data_addr  = 25'h300; data_we = 1'b0;
    @(negedge clk);
    chk("t2 data first", 32'({m_data_enable, m_instr_enable}), 2);
    serve(1'b1, 2, 32'h0000_D0D0, 1'b1, -1, "t2 data");
    data_enable = 1'b0;
    @(negedge clk);
    chk("t2 idle gap", 32'({busy, m_data_enable, m_instr_enable}), 0);
    @(negedge clk);
    chk("t2 instr next", 32'({m_data_enable, m_instr_enable}), 1);
    chk("t2 instr addr", 32'(m_instr_addr), 32'h200);
    serve(1'b0, 1, 32'h0000_1111, 1'b1, -1, "t2 instr");
    instr_enable = 1'b0;
    @(negedge clk);

    // controller never answers: 16 BUSY cycles then forced completion
    @(negedge clk);
    data_enable = 1'b1; data_addr = 25'h400;
    @(negedge clk);
    serve(1'b1, -1, 32'h0, 1'b1, -1, "t4 timeout");
    chk("t4 timeout_err set", 32'(timeout_err), 1);
    data_enable = 1'b0;
    repeat (4) @(negedge clk);
    chk("t4 timeout_err sticky", 32'(timeout_err), 1);

    // reset in the middle of a transaction
    data_enable = 1'b1; data_addr = 25'h500;
    @(negedge clk);
    @(negedge clk);
    chk("t5 granted", 32'(m_data_enable), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5 reset outputs", 32'({busy, m_data_enable, data_valid, timeout_err}), 0);
    chk("t5 reset m_data_addr", 32'(m_data_addr), 0);
    rst = 1'b0; data_enable = 1'b0;
    m_data_valid = 1'b1; m_data_result = 32'h5555_5555;
    @(negedge clk);
    m_data_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t5 stale valid ignored", 32'({data_valid, busy}), 0);
    end

    // fetch abandons mid-BUSY
    instr_enable = 1'b1; instr_addr = 25'h600;
    @(negedge clk);
    @(negedge clk);
    chk("t6 granted", 32'(m_instr_enable), 1);
    serve(1'b0, 3, 32'h6666_6666, 1'b0, 1, "t6 abandon");
    @(negedge clk);
    chk("t6 busy falls", 32'(busy), 0);

    // randomized run against the transaction-level model
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    losses = 0; gnt = 0; due = 0; c = 0; lat = 0;
    due_tmo = 0; tflag = 0; pbusy = 0; pie = 0; pde = 0;
    gi = $urandom_range(0, 3); gd = $urandom_range(0, 3);
    resp = '0; exp_res = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      ebusy = 1'b0; ev = 2'b00; een = 2'b00;
      if (due != 0) begin
        ebusy = 1'b1;
        ev    = (due == 2) ? 2'b10 : 2'b01;
        tflag = tflag | due_tmo;
        chk("rnd result", (due == 2) ? data_result : instr_result, exp_res);
        if (due == 2) begin data_enable = 1'b0; gd = $urandom_range(0, 3); end
        else begin instr_enable = 1'b0; gi = $urandom_range(0, 3); end
        due = 0; gnt = 0;
      end else begin
        if (gnt == 0 && !pbusy) begin
          // data wins unless the fetch has already lost STARVE arbitrations
          win_d = pde && (losses < STARVE);
          win_i = !win_d && pie;
          if (win_d && pie) losses = (losses + 1 > STARVE) ? STARVE : losses + 1;
          if (win_i) losses = 0;
          if (win_d || win_i) begin
            gnt  = win_d ? 2 : 1;
            c    = 0;
            lat  = $urandom_range(0, 18);
            resp = $urandom;
          end
        end
        if (gnt != 0) begin
          ebusy = 1'b1;
          een   = (gnt == 2) ? 2'b10 : 2'b01;
          if (gnt == 2) begin
            chk("rnd m_data_addr", 32'(m_data_addr), 32'(data_addr));
            chk("rnd m_data_wdata", m_data_wdata, data_wdata);
            chk("rnd m_data ctl", 32'({m_data_we, m_data_oplen, m_data_unsigned}),
                32'({data_we, data_oplen, data_unsigned}));
          end else begin
            chk("rnd m_instr_addr", 32'(m_instr_addr), 32'(instr_addr));
          end
          if (c == lat || c == TMO - 1) begin
            due     = gnt;
            due_tmo = (c != lat);
            exp_res = (c == lat) ? resp : c_BEEF;
          end
          c++;
        end
      end
      chk("rnd valids", 32'({data_valid, instr_valid}), 32'(ev));
      chk("rnd enables", 32'({m_data_enable, m_instr_enable}), 32'(een));
      chk("rnd busy", 32'(busy), 32'(ebusy));
      chk("rnd timeout_err", 32'(timeout_err), 32'(tflag));

      // controller: answer the granted port, random noise on the other one
      m_data_valid   = (gnt == 2) ? (due == 2 && !due_tmo) : ($urandom_range(0, 3) == 0);
      m_instr_valid  = (gnt == 1) ? (due == 1 && !due_tmo) : ($urandom_range(0, 3) == 0);
      m_data_result  = (gnt == 2) ? resp : $urandom;
      m_instr_result = (gnt == 1) ? resp : $urandom;

      if (!instr_enable) begin
        if (gi == 0) begin instr_enable = 1'b1; instr_addr = 25'($urandom); end
        else gi--;
      end
      if (!data_enable) begin
        if (gd == 0) begin
          data_enable   = 1'b1;
          data_addr     = 25'($urandom);
          data_we       = 1'($urandom);
          data_wdata    = $urandom;
          data_oplen    = 2'($urandom);
          data_unsigned = 1'($urandom);
        end else gd--;
      end
      pie   = instr_enable;
      pde   = data_enable;
      pbusy = ebusy;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
